// File: rtl/mux_sel_pkg.sv
// Shared types and default sizing for the arbiter and the multiplexer it drives.
package mux_sel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    VALID
  } arb_state_e;

  localparam int unsigned MUX_WIDTH      = 8;
  localparam int unsigned MUX_SEL_WIDTH  = 3;
  localparam int unsigned MUX_NUM_INPUTS = 8;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/select/output bundle between the arbiter, the multiplexer and the consumer.
interface mux_sel_arbiter_if
  import mux_sel_pkg::*;
#(
  parameter int unsigned WIDTH      = MUX_WIDTH,
  parameter int unsigned SEL_WIDTH  = MUX_SEL_WIDTH,
  parameter int unsigned NUM_INPUTS = MUX_NUM_INPUTS
);

  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] gnt;
  logic [SEL_WIDTH-1:0]  sel;
  logic [WIDTH-1:0]      mux_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_WIDTH-1:0]  out_src;

  // Arbiter side.
  modport master (
    input  req,
    input  mux_data,
    input  out_ready,
    output gnt,
    output sel,
    output out_valid,
    output out_data,
    output out_src
  );

  // Requester / multiplexer / consumer side.
  modport slave (
    output req,
    output mux_data,
    output out_ready,
    input  gnt,
    input  sel,
    input  out_valid,
    input  out_data,
    input  out_src
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational winner picker: rotate-mask priority encoder starting after `last`.
// With MUX_SEL_ARB_FIXED_PRIO_EN defined it is a plain lowest-index priority encoder.
module rr_pick #(
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned SEL_WIDTH  = 3
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_WIDTH-1:0]  last,
  output logic                  found,
  output logic [SEL_WIDTH-1:0]  idx
);

`ifdef MUX_SEL_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        idx   = SEL_WIDTH'(i);
      end
    end
  end
`else
  logic [NUM_INPUTS-1:0] masked;
  logic                  found_hi;
  logic                  found_lo;
  logic [SEL_WIDTH-1:0]  idx_hi;
  logic [SEL_WIDTH-1:0]  idx_lo;

  // Requests above `last` win first; otherwise wrap to the lowest asserted index.
  always_comb begin
    masked   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      masked[i] = req[i] && (SEL_WIDTH'(i) > last);
    end
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (masked[i] && !found_hi) begin
        found_hi = 1'b1;
        idx_hi   = SEL_WIDTH'(i);
      end
      if (req[i] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = SEL_WIDTH'(i);
      end
    end
    found = found_hi | found_lo;
    idx   = found_hi ? idx_hi : idx_lo;
  end
`endif

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving a multiplexer select and registering its output word.
// Define MUX_SEL_ARB_FIXED_PRIO_EN for fixed lowest-index priority (no `last` state).
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int unsigned WIDTH      = MUX_WIDTH,
  parameter int unsigned SEL_WIDTH  = MUX_SEL_WIDTH,
  parameter int unsigned NUM_INPUTS = MUX_NUM_INPUTS
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_arbiter_if.master  bus
);

  arb_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SEL_WIDTH-1:0] src_q, src_d;
  logic                 valid_q, valid_d;
  logic                 fresh_q, fresh_d;

  logic [SEL_WIDTH-1:0] pick_last;
  logic                 pick_found;
  logic [SEL_WIDTH-1:0] pick_idx;

`ifdef MUX_SEL_ARB_FIXED_PRIO_EN
  assign pick_last = '0;
`else
  logic [SEL_WIDTH-1:0] last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SEL_WIDTH'(NUM_INPUTS - 1);
    end else if (state_q == SELECT) begin
      last_q <= sel_q;
    end
  end

  assign pick_last = last_q;
`endif

  rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_pick (
    .req   (bus.req),
    .last  (pick_last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      fresh_q <= fresh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    fresh_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (pick_found) begin
          sel_d   = pick_idx;
          state_d = SELECT;
        end
      end
      SELECT: begin
        data_d  = bus.mux_data;
        src_d   = sel_q;
        valid_d = 1'b1;
        fresh_d = 1'b1;
        state_d = VALID;
      end
      VALID: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          if (pick_found) begin
            sel_d   = pick_idx;
            state_d = SELECT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // fresh_q marks only the first VALID cycle so backpressure never re-pulses gnt.
  assign bus.gnt       = fresh_q ? (NUM_INPUTS'(1) << sel_q) : '0;
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with a behavioural multiplexer on sel/mux_data.
module tb_mux_sel_arbiter;

  logic clk;
  logic rst_n;
  int unsigned errors;
  int unsigned checks;
  logic [7:0] mux_in [8];

  mux_sel_arbiter_if #(.WIDTH(8), .SEL_WIDTH(3), .NUM_INPUTS(8)) bus ();

  mux_sel_arbiter #(
    .WIDTH      (8),
    .SEL_WIDTH  (3),
    .NUM_INPUTS (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mux_data = mux_in[bus.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned wrap_exp [3];
    errors = 0;
    checks = 0;
    mux_in = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'h55, 8'hE5, 8'hF6, 8'h07};
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b1;
    repeat (2) step();

    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_sel", 32'(bus.sel), 0);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_src", 32'(bus.out_src), 0);

    // Single request from input 4.
    rst_n   = 1'b1;
    bus.req = 8'b0001_0000;
    step();
    check("single_sel", 32'(bus.sel), 4);
    check("single_early_valid", 32'(bus.out_valid), 0);
    check("single_early_gnt", 32'(bus.gnt), 0);
    bus.req = '0;
    step();
    check("single_valid", 32'(bus.out_valid), 1);
    check("single_data", 32'(bus.out_data), 32'h55);
    check("single_src", 32'(bus.out_src), 4);
    check("single_gnt", 32'(bus.gnt), 32'h10);
    step();
    check("single_gnt_off", 32'(bus.gnt), 0);
    check("single_valid_off", 32'(bus.out_valid), 0);

    // Rotation from a fresh reset: all requesting, consumer always ready.
    rst_n = 1'b0;
    step();
    rst_n   = 1'b1;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      int unsigned e;
`ifdef MUX_SEL_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = k % 8;
`endif
      step();
      check("rot_sel", 32'(bus.sel), e);
      check("rot_wait_valid", 32'(bus.out_valid), 0);
      step();
      check("rot_valid", 32'(bus.out_valid), 1);
      check("rot_src", 32'(bus.out_src), e);
      check("rot_data", 32'(bus.out_data), 32'(mux_in[e]));
      check("rot_gnt", 32'(bus.gnt), 32'(1) << e);
    end

    // Backpressure on the word from input 0.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_data", 32'(bus.out_data), 32'(mux_in[0]));
      check("bp_src", 32'(bus.out_src), 0);
      check("bp_sel", 32'(bus.sel), 0);
      check("bp_gnt", 32'(bus.gnt), 0);
    end
    bus.out_ready = 1'b1;
    step();
`ifdef MUX_SEL_ARB_FIXED_PRIO_EN
    check("bp_next_sel", 32'(bus.sel), 0);
`else
    check("bp_next_sel", 32'(bus.sel), 1);
`endif
    check("bp_accept_valid", 32'(bus.out_valid), 0);
    step();
    check("bp_next_valid", 32'(bus.out_valid), 1);
`ifdef MUX_SEL_ARB_FIXED_PRIO_EN
    check("bp_next_src", 32'(bus.out_src), 0);
`else
    check("bp_next_src", 32'(bus.out_src), 1);
`endif
    bus.req = '0;
    step();
    check("bp_idle_valid", 32'(bus.out_valid), 0);

    // Wrap and skip: grant 6 first, then requests on 0 and 6 only.
    bus.req = 8'b0100_0000;
    step();
    check("wrap_first_sel", 32'(bus.sel), 6);
    step();
    check("wrap_first_src", 32'(bus.out_src), 6);
    bus.req = 8'b0100_0001;
`ifdef MUX_SEL_ARB_FIXED_PRIO_EN
    wrap_exp = '{0, 0, 0};
`else
    wrap_exp = '{0, 6, 0};
`endif
    for (int k = 0; k < 3; k++) begin
      step();
      check("wrap_sel", 32'(bus.sel), wrap_exp[k]);
      step();
      check("wrap_src", 32'(bus.out_src), wrap_exp[k]);
      check("wrap_data", 32'(bus.out_data), 32'(mux_in[wrap_exp[k]]));
    end
    bus.req = '0;
    step();
    check("wrap_idle_valid", 32'(bus.out_valid), 0);

    // Request drops while in SELECT: word still delivered.
    bus.req = 8'b0000_1000;
    step();
    check("drop_sel", 32'(bus.sel), 3);
    bus.req = '0;
    step();
    check("drop_valid", 32'(bus.out_valid), 1);
    check("drop_src", 32'(bus.out_src), 3);
    check("drop_data", 32'(bus.out_data), 32'(mux_in[3]));
    check("drop_gnt", 32'(bus.gnt), 32'h08);
    step();
    check("drop_idle_valid", 32'(bus.out_valid), 0);

    // Asynchronous reset while in SELECT discards the word.
    bus.req = 8'b0010_0000;
    step();
    check("rstsel_sel_before", 32'(bus.sel), 5);
    rst_n = 1'b0;
    #1;
    check("rstsel_valid", 32'(bus.out_valid), 0);
    check("rstsel_sel", 32'(bus.sel), 0);
    check("rstsel_gnt", 32'(bus.gnt), 0);
    bus.req = '0;
    step();
    check("rstsel_gnt_later", 32'(bus.gnt), 0);
    check("rstsel_data", 32'(bus.out_data), 0);
    rst_n = 1'b1;
    step();
    check("rstsel_valid_after", 32'(bus.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
